// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths, queue entry type and helpers for the writeback controller
// Contents:
//   RAW_DEF   RF address width (2**RAW_DEF registers)
//   DW_DEF    data width
//   DEPTH_DEF writeback queue entries (power of 2, >= 2)
//   wb_entry_t  one queued RF write {rd, data}
//   onehot_rd   destination register -> one-hot register mask
package rf_wb_pkg;

    localparam int RAW_DEF   = 4;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;
    localparam int NREG      = 2 ** RAW_DEF;

    typedef struct packed {
        logic [RAW_DEF-1:0] rd;
        logic [DW_DEF-1:0]  data;
    } wb_entry_t;

    function automatic logic [NREG-1:0] onehot_rd(input logic [RAW_DEF-1:0] rd);
        logic [NREG-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// rtl/rf_writeback_ctrl_if.sv - producer handshakes and RF write port of the writeback stage
// Signals:
//   alu_valid_i/alu_rd_i/alu_data_i/alu_ready_o  ALU result channel
//   mem_valid_i/mem_rd_i/mem_data_i/mem_ready_o  load result channel
//   wen_o/write_addr_o/write_data_o              register file write port
// Modports:
//   master  producers and RF side (drives results, observes readies and writes)
//   slave   the writeback controller
interface rf_writeback_ctrl_if;
    import rf_wb_pkg::*;

    logic                alu_valid_i;
    logic [RAW_DEF-1:0]  alu_rd_i;
    logic [DW_DEF-1:0]   alu_data_i;
    logic                alu_ready_o;

    logic                mem_valid_i;
    logic [RAW_DEF-1:0]  mem_rd_i;
    logic [DW_DEF-1:0]   mem_data_i;
    logic                mem_ready_o;

    logic                wen_o;
    logic [RAW_DEF-1:0]  write_addr_o;
    logic [DW_DEF-1:0]   write_data_o;

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        input  alu_ready_o,
        output mem_valid_i, mem_rd_i, mem_data_i,
        input  mem_ready_o,
        input  wen_o, write_addr_o, write_data_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        output alu_ready_o,
        input  mem_valid_i, mem_rd_i, mem_data_i,
        output mem_ready_o,
        output wen_o, write_addr_o, write_data_o
    );

endinterface

// File: rtl/wb_entry_queue.sv
// rtl/wb_entry_queue.sv - 2-push/1-pop circular buffer of pending RF writes
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears pointers and count)
//   push_a, entry_a     first push of the cycle (older of the two)
//   push_b, entry_b     second push of the cycle (younger)
//   pop                 remove head entry; caller only pops when count != 0
//   count               registered occupancy
//   head                oldest entry
//   ord[k], valid[k]    entries in age order (k=0 oldest) and their validity
module wb_entry_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_a,
    input  wb_entry_t                  entry_a,
    input  logic                       push_b,
    input  wb_entry_t                  entry_b,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output wb_entry_t                  head,
    output wb_entry_t                  ord [DEPTH],
    output logic [DEPTH-1:0]           valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;

    // Pointer/count state: the only things a reset has to clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(push_a) + PW'(push_b);
            rd_ptr  <= rd_ptr + PW'(pop);
            count_q <= count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    // Entry storage needs no reset; validity comes from count.
    // When both push, entry_b lands one slot after entry_a to keep program order.
    always_ff @(posedge clk) begin
        if (push_a)
            mem[wr_ptr] <= entry_a;
        if (push_b)
            mem[push_a ? wr_ptr + PW'(1) : wr_ptr] <= entry_b;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ord[k]   = mem[rd_ptr + PW'(k)];
            valid[k] = (CW'(k) < count_q);
        end
    end

    assign count = count_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - in-order writeback queue feeding the register file write port
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         ALU and load result channels, RF write port (wen/addr/data)
//   pending_o           bit r set while any queued entry targets register r
//   rs_addr_i/rt_addr_i forwarding lookup addresses
//   rs_hit_o/rs_fwd_o   youngest queued write to rs_addr_i
//   rt_hit_o/rt_fwd_o   youngest queued write to rt_addr_i
// Register and data widths come from rf_wb_pkg because the queue entry type is shared.
module rf_writeback_ctrl
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rf_writeback_ctrl_if.slave   bus,
    output logic [NREG-1:0]      pending_o,
    input  logic [RAW_DEF-1:0]   rs_addr_i,
    input  logic [RAW_DEF-1:0]   rt_addr_i,
    output logic                 rs_hit_o,
    output logic [DW_DEF-1:0]    rs_fwd_o,
    output logic                 rt_hit_o,
    output logic [DW_DEF-1:0]    rt_fwd_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_LEFT = CW'(DEPTH - 1);

    logic [CW-1:0]     count;
    wb_entry_t         head;
    wb_entry_t         ord [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic              push_a;
    logic              push_b;
    logic              pop;

    // Credit is taken from the registered count only: a pop this cycle does
    // not free a slot for this cycle's producers. ALU wins the last free slot.
    assign bus.alu_ready_o = (count != FULL);
    assign bus.mem_ready_o = (count < ONE_LEFT) || ((count == ONE_LEFT) && !bus.alu_valid_i);

    assign push_a = bus.alu_valid_i && bus.alu_ready_o;
    assign push_b = bus.mem_valid_i && bus.mem_ready_o;
    assign pop    = (count != '0);

    wb_entry_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_a  (push_a),
        .entry_a ('{rd: bus.alu_rd_i, data: bus.alu_data_i}),
        .push_b  (push_b),
        .entry_b ('{rd: bus.mem_rd_i, data: bus.mem_data_i}),
        .pop     (pop),
        .count   (count),
        .head    (head),
        .ord     (ord),
        .valid   (valid)
    );

    assign bus.wen_o        = pop;
    assign bus.write_addr_o = head.rd;
    assign bus.write_data_o = head.data;

    // Scan oldest to youngest so later matches overwrite earlier ones:
    // the youngest matching entry ends up driving the forward data.
    always_comb begin
        pending_o = '0;
        rs_hit_o  = 1'b0;
        rs_fwd_o  = '0;
        rt_hit_o  = 1'b0;
        rt_fwd_o  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k]) begin
                pending_o = pending_o | onehot_rd(ord[k].rd);
                if (ord[k].rd == rs_addr_i) begin
                    rs_hit_o = 1'b1;
                    rs_fwd_o = ord[k].data;
                end
                if (ord[k].rd == rt_addr_i) begin
                    rt_hit_o = 1'b1;
                    rt_fwd_o = ord[k].data;
                end
            end
        end
    end

endmodule
